// File: rtl/gray_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : gray_stream_tx
// Purpose  : Streams NUM_PIXELS gray values from a sync-read ROM as one
//            gap-free gray_valid burst, followed by a guaranteed low gap.
//            Optional range checker enabled by GRAY_STREAM_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gray_stream_tx #(
    parameter int NUM_PIXELS = 100,
    parameter int ADDR_W     = 7,
    parameter int GAP        = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic              gray_valid,
    output logic [7:0]        gray_data,
    output logic              range_err
);

    localparam int CNT_W = 7;
    localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_issue_cnt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_q_valid;
    logic               r_gray_valid;
    logic [7:0]         r_gray_data;
    logic               w_rom_rd;
    logic               w_last_pix;
    logic               w_gap_last;

    // Issue count doubles as the ROM address; it stops at NUM_PIXELS, never wraps.
    assign w_rom_rd   = (r_state == S_FETCH) ||
                        ((r_state == S_STREAM) && (r_issue_cnt < CNT_W'(NUM_PIXELS)));
    assign w_last_pix = r_gray_valid && (r_out_cnt == CNT_W'(NUM_PIXELS - 1));
    assign w_gap_last = (r_state == S_GAP) && (r_gap_cnt == GAP_W'(GAP - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start)      w_state_nxt = S_FETCH;
            S_FETCH:                  w_state_nxt = S_STREAM;
            S_STREAM: if (w_last_pix) w_state_nxt = S_GAP;
            S_GAP:    if (w_gap_last) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_cnt  <= '0;
            r_out_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_q_valid    <= 1'b0;
            r_gray_valid <= 1'b0;
            r_gray_data  <= 8'd0;
        end else begin
            if (r_state == S_IDLE) begin
                r_issue_cnt <= '0;
            end else if (w_rom_rd) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end

            if (r_state == S_IDLE) begin
                r_out_cnt <= '0;
            end else if (r_gray_valid) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end

            if (r_state != S_GAP) begin
                r_gap_cnt <= '0;
            end else begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end

            // Two-stage latency: address -> rom_q -> gray_data.
            r_q_valid    <= w_rom_rd;
            r_gray_valid <= r_q_valid;
            r_gray_data  <= r_q_valid ? rom_q : 8'd0;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = w_gap_last;
    assign rom_rd     = w_rom_rd;
    assign rom_addr   = w_rom_rd ? ADDR_W'(r_issue_cnt) : '0;
    assign gray_valid = r_gray_valid;
    assign gray_data  = r_gray_data;

`ifdef GRAY_STREAM_RANGE_CHECK_EN
    logic r_range_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_range_err <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_range_err <= 1'b0;
        end else if (r_gray_valid && ((r_gray_data == 8'd0) || (r_gray_data > 8'd6))) begin
            r_range_err <= 1'b1;
        end
    end

    assign range_err = r_range_err;
`else
    assign range_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_stream_tx
// Purpose  : Directed self-checking bench for gray_stream_tx (100/1 and 1/3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_stream_tx;

    localparam int N  = 100;
    localparam int G  = 1;
    localparam int NS = 1;
    localparam int GS = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy, done, rom_rd, gray_valid, range_err;
    logic [6:0] rom_addr;
    logic [7:0] rom_q, gray_data;

    logic       start_s;
    logic       busy_s, done_s, rom_rd_s, gray_valid_s, range_err_s;
    logic [6:0] rom_addr_s;
    logic [7:0] rom_q_s, gray_data_s;

    logic [7:0] rom [0:127];
    int         n_checks;
    int         n_errors;
    int         hist [0:6];

    gray_stream_tx #(.NUM_PIXELS(N), .ADDR_W(7), .GAP(G)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_q(rom_q),
        .gray_valid(gray_valid), .gray_data(gray_data), .range_err(range_err)
    );

    gray_stream_tx #(.NUM_PIXELS(NS), .ADDR_W(7), .GAP(GS)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
        .rom_rd(rom_rd_s), .rom_addr(rom_addr_s), .rom_q(rom_q_s),
        .gray_valid(gray_valid_s), .gray_data(gray_data_s), .range_err(range_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_rd)   rom_q   <= rom[rom_addr];
        if (rom_rd_s) rom_q_s <= rom[rom_addr_s];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is in an IDLE cycle k; pulses start and checks cycles k+1..k+N+G+4.
    task automatic run_frame(input string tag);
        int   mv, md, mdone, mbusy, mrd, merr;
        logic exp_v;
        logic [7:0] exp_d;
        logic err_m;
        mv = 0; md = 0; mdone = 0; mbusy = 0; mrd = 0; merr = 0; err_m = 1'b0;
        for (int i = 0; i < 7; i++) hist[i] = 0;
        start = 1'b1;
        for (int t = 1; t <= N + G + 4; t++) begin
            tick();
            if (t == 1) start = 1'b0;
            exp_v = (t >= 3) && (t <= N + 2);
            exp_d = exp_v ? rom[t-3] : 8'd0;
            if (gray_valid !== exp_v) mv++;
            if (gray_data !== exp_d) md++;
            if (done !== (t == N + 2 + G)) mdone++;
            if (busy !== (t <= N + 2 + G)) mbusy++;
            if (rom_rd !== (t <= N)) mrd++;
            if ((t <= N) && (rom_addr !== 7'(t - 1))) mrd++;
            if (range_err !== err_m) merr++;
`ifdef GRAY_STREAM_RANGE_CHECK_EN
            if (exp_v && ((exp_d == 8'd0) || (exp_d > 8'd6))) err_m = 1'b1;
`endif
            if (gray_valid && (gray_data >= 8'd1) && (gray_data <= 8'd6)) hist[gray_data]++;
        end
        check({tag, "_valid"}, mv, 0);
        check({tag, "_data"}, md, 0);
        check({tag, "_done"}, mdone, 0);
        check({tag, "_busy"}, mbusy, 0);
        check({tag, "_rom"}, mrd, 0);
        check({tag, "_range_err"}, merr, 0);
    endtask

    initial begin
        int bursts, dones, low, len, bad_gap, bad_len, first_rise, mism;
        logic prev_v;
        int exp_hist [0:6];

        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 128; i++) rom[i] = 8'((i % 6) + 1);
        reset = 1'b1; start = 1'b0; start_s = 1'b0;

        // Reset held 3 cycles
        tick(); tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_rd", rom_rd, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_valid", gray_valid, 0);
        check("rst_data", gray_data, 0);
        check("rst_range_err", range_err, 0);
        reset = 1'b0;
        tick();

        // Single frame, ROM[i] = (i%6)+1
        run_frame("frame1");
        exp_hist = '{0, 17, 17, 17, 17, 16, 16};
        for (int v = 1; v <= 6; v++) check($sformatf("frame1_cnt%0d", v), hist[v], exp_hist[v]);

        // start held high for three frames
        bursts = 0; dones = 0; low = 0; len = 0; bad_gap = 0; bad_len = 0;
        first_rise = 0; prev_v = 1'b0;
        for (int i = 0; i < 7; i++) hist[i] = 0;
        start = 1'b1;
        for (int t = 1; t <= 320; t++) begin
            tick();
            if (t == 209) start = 1'b0;
            if (gray_valid && !prev_v) begin
                bursts++;
                if (bursts == 1) first_rise = t;
                if ((bursts > 1) && (low != G + 3)) bad_gap++;
                len = 0;
            end
            if (!gray_valid && prev_v && (len != N)) bad_len++;
            if (gray_valid) begin
                len++;
                low = 0;
            end else begin
                low++;
            end
            if (done) dones++;
            if (gray_valid && (gray_data >= 8'd1) && (gray_data <= 8'd6)) hist[gray_data]++;
            prev_v = gray_valid;
        end
        check("held_first_rise", first_rise, 3);
        check("held_bursts", bursts, 3);
        check("held_dones", dones, 3);
        check("held_gap_len", bad_gap, 0);
        check("held_burst_len", bad_len, 0);
        check("held_cnt1", hist[1], 51);
        check("held_cnt6", hist[6], 48);

        // Reset after 40 pixels
        start = 1'b1;
        for (int t = 1; t <= 42; t++) begin
            tick();
            if (t == 1) start = 1'b0;
        end
        check("abort_streaming", gray_valid, 1);
        reset = 1'b1;
        tick();
        check("abort_valid", gray_valid, 0);
        check("abort_rom_rd", rom_rd, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        dones = 0;
        for (int t = 0; t < 110; t++) begin
            tick();
            if (done || gray_valid) dones++;
        end
        check("abort_no_done", dones, 0);
        run_frame("after_abort");
        check("after_abort_cnt5", hist[5], 16);

        // Out-of-range pixel at index 10, then a clean frame clears the flag
        rom[10] = 8'd0;
        run_frame("range");
        rom[10] = 8'd5;
        run_frame("range_clear");

        // NUM_PIXELS=1, GAP=3 instance; start during busy must be ignored
        mism = 0;
        start_s = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 1) start_s = 1'b0;
            if (t == 2) start_s = 1'b1;
            if (t == 6) start_s = 1'b0;
            if (gray_valid_s !== (t == 3)) mism++;
            if (gray_data_s !== ((t == 3) ? rom[0] : 8'd0)) mism++;
            if (done_s !== (t == 6)) mism++;
            if (busy_s !== (t <= 6)) mism++;
            if (rom_rd_s !== (t == 1)) mism++;
        end
        check("small_frame", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
